// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// digit code type, segment font and BCD digit-count helper.
package seg_pkg;

    // Digit codes held in the display register; 0-F map to hex glyphs.
    typedef enum logic [4:0] {
        CODE_0     = 5'd0,
        CODE_1     = 5'd1,
        CODE_2     = 5'd2,
        CODE_3     = 5'd3,
        CODE_4     = 5'd4,
        CODE_5     = 5'd5,
        CODE_6     = 5'd6,
        CODE_7     = 5'd7,
        CODE_8     = 5'd8,
        CODE_9     = 5'd9,
        CODE_A     = 5'd10,
        CODE_B     = 5'd11,
        CODE_C     = 5'd12,
        CODE_D     = 5'd13,
        CODE_E     = 5'd14,
        CODE_F     = 5'd15,
        CODE_DASH  = 5'd16,
        CODE_BLANK = 5'd17
    } digit_code_t;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] FONT_0     = 7'h3F;
    localparam logic [6:0] FONT_1     = 7'h06;
    localparam logic [6:0] FONT_2     = 7'h5B;
    localparam logic [6:0] FONT_3     = 7'h4F;
    localparam logic [6:0] FONT_4     = 7'h66;
    localparam logic [6:0] FONT_5     = 7'h6D;
    localparam logic [6:0] FONT_6     = 7'h7D;
    localparam logic [6:0] FONT_7     = 7'h07;
    localparam logic [6:0] FONT_8     = 7'h7F;
    localparam logic [6:0] FONT_9     = 7'h6F;
    localparam logic [6:0] FONT_A     = 7'h77;
    localparam logic [6:0] FONT_B     = 7'h7C;
    localparam logic [6:0] FONT_C     = 7'h39;
    localparam logic [6:0] FONT_D     = 7'h5E;
    localparam logic [6:0] FONT_E     = 7'h79;
    localparam logic [6:0] FONT_F     = 7'h71;
    localparam logic [6:0] FONT_DASH  = 7'h40;
    localparam logic [6:0] FONT_BLANK = 7'h00;

    function automatic logic [6:0] seg_font(input digit_code_t code);
        logic [6:0] f;
        case (code)
            CODE_0:    f = FONT_0;
            CODE_1:    f = FONT_1;
            CODE_2:    f = FONT_2;
            CODE_3:    f = FONT_3;
            CODE_4:    f = FONT_4;
            CODE_5:    f = FONT_5;
            CODE_6:    f = FONT_6;
            CODE_7:    f = FONT_7;
            CODE_8:    f = FONT_8;
            CODE_9:    f = FONT_9;
            CODE_A:    f = FONT_A;
            CODE_B:    f = FONT_B;
            CODE_C:    f = FONT_C;
            CODE_D:    f = FONT_D;
            CODE_E:    f = FONT_E;
            CODE_F:    f = FONT_F;
            CODE_DASH: f = FONT_DASH;
            default:   f = FONT_BLANK;
        endcase
        return f;
    endfunction

    // Number of BCD digits needed to hold any value of width w.
    function automatic int unsigned seg_nbcd(input int unsigned w);
        return (w * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/seg_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one add-3/shift step
// per cycle. o_busy is high for exactly VAL_W cycles after i_start;
// o_done pulses in the following cycle with o_bcd holding the result.
module seg_bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int unsigned VAL_W = 32,
    parameter int unsigned NBCD  = seg_nbcd(VAL_W)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [VAL_W-1:0]    i_bin,
    output logic                o_busy,
    output logic                o_done,
    output logic [4*NBCD-1:0]   o_bcd
);

    localparam int unsigned CW = $clog2(VAL_W);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [VAL_W-1:0]    r_shift;
    logic [4*NBCD-1:0]   r_bcd;
    logic                r_busy;
    logic                r_done;
    logic [4*NBCD-1:0]   w_adj;
    logic [4*NBCD:0]     w_step;

    // Add 3 to every BCD digit >= 5, then shift in the next binary bit.
    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < NBCD; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
        w_step = {w_adj, r_shift[VAL_W-1]};
    end

    // Conversion FSM with registered busy/done outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_shift <= i_bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_shift <= r_shift << 1;
                    r_bcd   <= w_step[4*NBCD-1:0];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(VAL_W - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment display driver: captures a value in hex or decimal,
// holds it in a display register and scans DIGITS select lines with
// ghost-blanking gaps. Optional build macro LZ_BLANK_EN enables
// leading-zero blanking in decimal mode.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned VAL_W       = 32,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 2,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned SEL_ACT_LOW = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [VAL_W-1:0]  i_value,
    input  logic              i_load,
    input  logic              i_hex,
    input  logic [DIGITS-1:0] i_dp,
    output logic              o_busy,
    output logic [6:0]        o_num,
    output logic              o_dp,
    output logic [DIGITS-1:0] o_sel
);

    localparam int unsigned NBCD  = seg_nbcd(VAL_W);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PS_W  = $clog2(SCAN_DIV);

    localparam logic [6:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACT_LOW != 0) ? '1 : '0;
    localparam logic [DIGITS-1:0] SEL_ONE = 1;

    // Load / pending state
    logic                r_pend_vld;
    logic [VAL_W-1:0]    r_pend_value;
    logic                r_pend_hex;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [DIGITS-1:0]   r_cv_dp;

    // Display register
    digit_code_t         r_disp [DIGITS];
    logic [DIGITS-1:0]   r_disp_dp;

    // Scan and output registers
    logic [PS_W-1:0]     r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_sel;
    logic [6:0]          r_num;
    logic                r_dp;

    logic                w_cv_busy;
    logic                w_cv_done;
    logic [4*NBCD-1:0]   w_cv_bcd;
    logic [VAL_W-1:0]    w_src_value;
    logic                w_src_hex;
    logic [DIGITS-1:0]   w_src_dp;
    logic                w_accept;
    logic                w_to_pend;
    logic [4*DIGITS-1:0] w_hex;
    logic [4*DIGITS-1:0] w_bcd_low;
    logic                w_ovf;
    digit_code_t         w_hex_code [DIGITS];
    digit_code_t         w_dec_raw  [DIGITS];
    digit_code_t         w_dec_code [DIGITS];
    logic [PS_W-1:0]     w_presc_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;

    // A waiting pending load takes the place of i_load once the converter is idle.
    assign w_src_value = r_pend_vld ? r_pend_value : i_value;
    assign w_src_hex   = r_pend_vld ? r_pend_hex   : i_hex;
    assign w_src_dp    = r_pend_vld ? r_pend_dp    : i_dp;
    assign w_accept    = !w_cv_busy && (r_pend_vld || i_load);
    assign w_to_pend   = i_load && (w_cv_busy || r_pend_vld);

    seg_bin2bcd_seq #(
        .VAL_W (VAL_W),
        .NBCD  (NBCD)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_accept && !w_src_hex),
        .i_bin   (w_src_value),
        .o_busy  (w_cv_busy),
        .o_done  (w_cv_done),
        .o_bcd   (w_cv_bcd)
    );

    if (VAL_W >= 4*DIGITS) begin : g_hex_trunc
        assign w_hex = w_src_value[4*DIGITS-1:0];
    end else begin : g_hex_ext
        assign w_hex = {{(4*DIGITS-VAL_W){1'b0}}, w_src_value};
    end

    if (NBCD > DIGITS) begin : g_bcd_ovf
        assign w_bcd_low = w_cv_bcd[4*DIGITS-1:0];
        assign w_ovf     = |w_cv_bcd[4*NBCD-1:4*DIGITS];
    end else if (NBCD == DIGITS) begin : g_bcd_exact
        assign w_bcd_low = w_cv_bcd;
        assign w_ovf     = 1'b0;
    end else begin : g_bcd_ext
        assign w_bcd_low = {{(4*(DIGITS-NBCD)){1'b0}}, w_cv_bcd};
        assign w_ovf     = 1'b0;
    end

    // Digit codes for a hex load and for a finished decimal conversion.
    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_hex_code[i] = digit_code_t'({1'b0, w_hex[4*i +: 4]});
            w_dec_raw[i]  = w_ovf ? CODE_DASH
                                  : digit_code_t'({1'b0, w_bcd_low[4*i +: 4]});
        end
    end

    // Leading-zero blanking, walking from the leftmost digit down.
    always_comb begin
`ifdef LZ_BLANK_EN
        logic        v_keep;
        int unsigned v_i;
        v_keep = 1'b0;
        v_i    = 0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            v_i = DIGITS - 1 - k;
            v_keep = v_keep || (w_dec_raw[v_i] != CODE_0) || r_cv_dp[v_i] || (v_i == 0);
            w_dec_code[v_i] = v_keep ? w_dec_raw[v_i] : CODE_BLANK;
        end
`else
        for (int unsigned i = 0; i < DIGITS; i++) begin
            w_dec_code[i] = w_dec_raw[i];
        end
`endif
    end

    // Load acceptance, pending slot and atomic display register update.
    // A hex accept in the completion cycle is the later load, so it is written last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_vld   <= 1'b0;
            r_pend_value <= '0;
            r_pend_hex   <= 1'b0;
            r_pend_dp    <= '0;
            r_cv_dp      <= '0;
            r_disp_dp    <= '0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                r_disp[i] <= CODE_0;
            end
        end else begin
            if (w_cv_done) begin
                r_disp_dp <= r_cv_dp;
                for (int unsigned i = 0; i < DIGITS; i++) begin
                    r_disp[i] <= w_dec_code[i];
                end
            end
            if (w_accept) begin
                if (w_src_hex) begin
                    r_disp_dp <= w_src_dp;
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        r_disp[i] <= w_hex_code[i];
                    end
                end else begin
                    r_cv_dp <= w_src_dp;
                end
            end
            if (w_to_pend) begin
                r_pend_vld   <= 1'b1;
                r_pend_value <= i_value;
                r_pend_hex   <= i_hex;
                r_pend_dp    <= i_dp;
            end else if (w_accept && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // Next prescaler / digit index.
    always_comb begin
        w_presc_nxt = r_presc + 1'b1;
        w_idx_nxt   = r_idx;
        if (r_presc == PS_W'(SCAN_DIV - 1)) begin
            w_presc_nxt = '0;
            w_idx_nxt   = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    // Scan counters and outputs; outputs are derived from the next counter
    // values so select and segments always change on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_sel   <= SEL_OFF;
            r_num   <= SEG_OFF;
            r_dp    <= DP_OFF;
        end else begin
            r_presc <= w_presc_nxt;
            r_idx   <= w_idx_nxt;
            r_num   <= seg_font(r_disp[w_idx_nxt]) ^ SEG_OFF;
            r_dp    <= r_disp_dp[w_idx_nxt] ^ DP_OFF;
            if (w_presc_nxt < PS_W'(BLANK_CYC)) begin
                r_sel <= SEL_OFF;
            end else begin
                r_sel <= SEL_OFF ^ (SEL_ONE << w_idx_nxt);
            end
        end
    end

    assign o_busy = w_cv_busy;
    assign o_num  = r_num;
    assign o_dp   = r_dp;
    assign o_sel  = r_sel;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (DIGITS=4, VAL_W=16, SCAN_DIV=6,
// BLANK_CYC=1, active-low outputs). Build with LZ_BLANK_EN to cover
// leading-zero blanking.
module tb_seg_scan_display;

    // Active-low glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S3 = 7'h30;
    localparam logic [6:0] S4 = 7'h19;
    localparam logic [6:0] S7 = 7'h78;
    localparam logic [6:0] SB = 7'h03;
    localparam logic [6:0] SE = 7'h06;
    localparam logic [6:0] SF = 7'h0E;
    localparam logic [6:0] SD = 7'h3F;
    localparam logic [6:0] SX = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_value = '0;
    logic        i_load = 1'b0;
    logic        i_hex = 1'b0;
    logic [3:0]  i_dp = '0;
    logic        o_busy;
    logic [6:0]  o_num;
    logic        o_dp;
    logic [3:0]  o_sel;

    int          n_chk = 0;
    int          n_err = 0;
    logic        saw_two = 1'b0;
    logic [6:0]  f_seg [4];
    logic [3:0]  f_dp;
    int          n;

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS      (4),
        .VAL_W       (16),
        .SCAN_DIV    (6),
        .BLANK_CYC   (1),
        .SEG_ACT_LOW (1),
        .SEL_ACT_LOW (1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_value (i_value),
        .i_load  (i_load),
        .i_hex   (i_hex),
        .i_dp    (i_dp),
        .o_busy  (o_busy),
        .o_num   (o_num),
        .o_dp    (o_dp),
        .o_sel   (o_sel)
    );

    // Flags any moment digit2 shows a '2' (value 200 must never appear).
    always @(negedge clk) begin
        if (o_sel == 4'b1011 && o_num == S2) saw_two = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] v, input logic hex, input logic [3:0] dp);
        @(negedge clk);
        i_value = v;
        i_hex   = hex;
        i_dp    = dp;
        i_load  = 1'b1;
        @(negedge clk);
        i_load  = 1'b0;
    endtask

    // Counts consecutive busy samples; returns on the first idle negedge.
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (o_busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // One full scan period: 4 digits x 6 cycles.
    task automatic read_frame(input string tag);
        int blanks;
        int bad;
        blanks = 0;
        bad = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            case (o_sel)
                4'b1111: blanks++;
                4'b1110: begin f_seg[0] = o_num; f_dp[0] = o_dp; end
                4'b1101: begin f_seg[1] = o_num; f_dp[1] = o_dp; end
                4'b1011: begin f_seg[2] = o_num; f_dp[2] = o_dp; end
                4'b0111: begin f_seg[3] = o_num; f_dp[3] = o_dp; end
                default: bad++;
            endcase
        end
        chk({tag, "_blank"}, blanks, 4);
        chk({tag, "_sel"}, bad, 0);
    endtask

    task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0, input logic [3:0] edp);
        read_frame(tag);
        chk({tag, "_d3"}, f_seg[3], e3);
        chk({tag, "_d2"}, f_seg[2], e2);
        chk({tag, "_d1"}, f_seg[1], e1);
        chk({tag, "_d0"}, f_seg[0], e0);
        chk({tag, "_dp"}, f_dp, edp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_sel", o_sel, 4'hF);
        chk("rst_num", o_num, SX);
        chk("rst_dp", o_dp, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("zero", S0, S0, S0, S0, 4'hF);

        // Decimal 1234
        load(16'd1234, 1'b0, 4'b0000);
        wait_busy(n);
        chk("busy_1234", n, 16);
        repeat (3) @(negedge clk);
        check_frame("d1234", S1, S2, S3, S4, 4'hF);

        // Decimal overflow
        load(16'd12345, 1'b0, 4'b0000);
        wait_busy(n);
        chk("busy_12345", n, 16);
        repeat (3) @(negedge clk);
        check_frame("ovf", SD, SD, SD, SD, 4'hF);

        // Hex BEEF with dp on digit0, no busy
        load(16'hBEEF, 1'b1, 4'b0001);
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_busy) n++;
            @(negedge clk);
        end
        chk("hex_busy", n, 0);
        check_frame("hex", SB, SE, SE, SF, 4'b1110);

        // Pending overwrite: 100, then 200 and 300 while busy
        saw_two = 1'b0;
        load(16'd100, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        load(16'd200, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        load(16'd300, 1'b0, 4'b0000);
        wait_busy(n);
        chk("first_fall", o_busy, 1'b0);
        @(negedge clk);
        chk("pend_start", o_busy, 1'b1);
        wait_busy(n);
        chk("busy_300", n, 16);
        repeat (3) @(negedge clk);
`ifdef LZ_BLANK_EN
        check_frame("d300", SX, S3, S0, S0, 4'hF);
`else
        check_frame("d300", S0, S3, S0, S0, 4'hF);
`endif
        chk("no_200", saw_two, 1'b0);

        // Small decimal value: leading zeros
        load(16'd7, 1'b0, 4'b0000);
        wait_busy(n);
        chk("busy_7", n, 16);
        repeat (3) @(negedge clk);
`ifdef LZ_BLANK_EN
        check_frame("lz7", SX, SX, SX, S7, 4'hF);
        load(16'd7, 1'b0, 4'b0100);
        wait_busy(n);
        repeat (3) @(negedge clk);
        check_frame("lz7dp", SX, S0, S0, S7, 4'b1011);
`else
        check_frame("d7", S0, S0, S0, S7, 4'hF);
`endif

        // Reset mid-conversion with a pending load
        load(16'd4321, 1'b0, 4'b0000);
        repeat (3) @(negedge clk);
        load(16'd999, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_sel", o_sel, 4'hF);
        chk("mrst_num", o_num, SX);
        chk("mrst_dp", o_dp, 1'b1);
        chk("mrst_busy", o_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_busy) n++;
        end
        chk("mrst_nopend", n, 0);
        check_frame("mrst", S0, S0, S0, S0, 4'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
